// File: rtl/store_commit_unit.sv
// store_commit_unit: buffers resolved stores by ROB entry and writes them to memory byte by byte at commit
`ifndef ENTRY_RANGE
`define ENTRY_RANGE 3:0
`endif
`ifndef SType
`define SType 3'd1
`endif
module store_commit_unit (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                lsb_store_addressed,
  input  logic [`ENTRY_RANGE] lsb_store_entry,
  input  logic [31:0]         lsb_store_addr,
  input  logic [31:0]         lsb_store_data,
  input  logic [1:0]          lsb_store_width,
  input  logic                rob_commit,
  input  logic [2:0]          rob_op_type_commit,
  input  logic [`ENTRY_RANGE] rob_entry_commit,
  input  logic                roll_back,
  output logic                finish_store,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_wr,
  output logic [31:0]         mem_a,
  output logic [7:0]          mem_dout,
  input  logic                io_buffer_full,
  output logic                store_err
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [15:0] valid;
  logic [31:0] t_addr [16];
  logic [31:0] t_data [16];
  logic [1:0]  t_width [16];
  logic [31:0] w_addr, w_data, a_nx;
  logic [1:0]  w_last, cnt;
  logic [7:0]  dout_nx;
  logic        commit, hit, stall, fire, req_nx, wr_nx, fin_nx, err_nx;
  // FSM state register; rdy_in low freezes everything
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) state <= IDLE;
    else if (rdy_in) state <= state_nx;
  // commit decode and next-state selection
  always_comb begin
    commit = rob_commit && rob_op_type_commit == `SType;
    hit = commit && valid[rob_entry_commit];
    stall = io_buffer_full && w_addr[17:16] == 2'b11;
    fire = mem_gnt && !stall;
    state_nx = state == IDLE ? (commit ? (hit ? WRITE : DONE) : IDLE) :
               state == WRITE ? (fire && cnt == w_last ? DONE : WRITE) : IDLE;
  end
  // next values of the registered outputs
  always_comb begin
    req_nx = state == IDLE ? hit : state == WRITE;
    wr_nx = state == WRITE && fire;
    a_nx = wr_nx ? w_addr + {30'b0, cnt} : mem_a;
    dout_nx = wr_nx ? w_data[{cnt, 3'b000} +: 8] : mem_dout;
    fin_nx = state == DONE;
    err_nx = store_err || (state == IDLE && commit && !hit);
  end
  // registered outputs, working registers, byte counter and valid bits
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      valid <= '0;
      cnt <= '0;
      w_addr <= '0;
      w_data <= '0;
      w_last <= '0;
      mem_req <= 1'b0;
      mem_wr <= 1'b0;
      mem_a <= '0;
      mem_dout <= '0;
      finish_store <= 1'b0;
      store_err <= 1'b0;
    end else if (rdy_in) begin
      mem_req <= req_nx;
      mem_wr <= wr_nx;
      mem_a <= a_nx;
      mem_dout <= dout_nx;
      finish_store <= fin_nx;
      store_err <= err_nx;
      if (state == IDLE && hit) begin
        w_addr <= t_addr[rob_entry_commit];
        w_data <= t_data[rob_entry_commit];
        w_last <= t_width[rob_entry_commit] == 2'd0 ? 2'd0 : t_width[rob_entry_commit] == 2'd1 ? 2'd1 : 2'd3;
        cnt <= 2'd0;
        valid[rob_entry_commit] <= 1'b0;
      end
      if (wr_nx) cnt <= cnt + 2'd1;
      if (roll_back) valid <= '0;
      if (lsb_store_addressed) valid[lsb_store_entry] <= 1'b1;
    end
  // record storage; commits read the old record before an overlapping write lands
  always_ff @(posedge clk_in)
    if (rdy_in && lsb_store_addressed) begin
      t_addr[lsb_store_entry] <= lsb_store_addr;
      t_data[lsb_store_entry] <= lsb_store_data;
      t_width[lsb_store_entry] <= lsb_store_width;
    end
endmodule

// File: tb/tb_store_commit_unit.sv
// tb_store_commit_unit: directed self-checking bench for store_commit_unit
`ifndef ENTRY_RANGE
`define ENTRY_RANGE 3:0
`endif
`ifndef SType
`define SType 3'd1
`endif
module tb_store_commit_unit;
  logic clk_in = 0, rst_in = 1, rdy_in = 1, lsb_store_addressed = 0;
  logic [`ENTRY_RANGE] lsb_store_entry = 0, rob_entry_commit = 0;
  logic [31:0] lsb_store_addr = 0, lsb_store_data = 0, mem_a;
  logic [1:0] lsb_store_width = 0;
  logic rob_commit = 0, roll_back = 0, mem_gnt = 1, io_buffer_full = 0;
  logic [2:0] rob_op_type_commit = 0;
  logic finish_store, mem_req, mem_wr, store_err;
  logic [7:0] mem_dout;
  int tests = 0, fails = 0;

  store_commit_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .lsb_store_addressed(lsb_store_addressed), .lsb_store_entry(lsb_store_entry),
    .lsb_store_addr(lsb_store_addr), .lsb_store_data(lsb_store_data), .lsb_store_width(lsb_store_width),
    .rob_commit(rob_commit), .rob_op_type_commit(rob_op_type_commit), .rob_entry_commit(rob_entry_commit),
    .roll_back(roll_back), .finish_store(finish_store), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_wr(mem_wr), .mem_a(mem_a), .mem_dout(mem_dout), .io_buffer_full(io_buffer_full), .store_err(store_err)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task bad(input string tag);
    fails++;
    $error("FAIL %s: mem_wr=%0h mem_a=%0h mem_dout=%0h mem_req=%0h finish=%0h err=%0h", tag, mem_wr, mem_a, mem_dout, mem_req, finish_store, store_err);
  endtask

  task step;
    @(posedge clk_in);
    #1;
  endtask

  task rec(input logic [3:0] e, input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    lsb_store_addressed = 1; lsb_store_entry = e; lsb_store_addr = a; lsb_store_data = d; lsb_store_width = w;
    step;
    lsb_store_addressed = 0;
  endtask

  task commit(input logic [3:0] e, input logic [2:0] op);
    rob_commit = 1; rob_op_type_commit = op; rob_entry_commit = e;
    step;
    rob_commit = 0;
  endtask

  task wr(input logic [31:0] a, input logic [7:0] d);
    step;
    tests++; if (mem_wr !== 1'b1) bad("wr_en");
    tests++; if (mem_a !== a) bad("wr_addr");
    tests++; if (mem_dout !== d) bad("wr_data");
  endtask

  task idle_wr;
    step;
    tests++; if (mem_wr !== 1'b0) bad("no_wr");
  endtask

  task fin;
    step;
    tests++; if (finish_store !== 1'b1) bad("finish");
    tests++; if (mem_wr !== 1'b0) bad("fin_wr");
    tests++; if (mem_req !== 1'b0) bad("fin_req");
    step;
    tests++; if (finish_store !== 1'b0) bad("finish_pulse");
  endtask

  initial begin
    #2;
    tests++; if (mem_req !== 1'b0) bad("rst_req");
    tests++; if (mem_wr !== 1'b0) bad("rst_wr");
    tests++; if (finish_store !== 1'b0) bad("rst_fin");
    tests++; if (store_err !== 1'b0) bad("rst_err");
    tests++; if (mem_a !== 32'h0) bad("rst_a");
    step; step;
    rst_in = 0;
    step;

    rec(3, 32'h100, 32'hA1B2C3D4, 2);
    commit(3, `SType);
    tests++; if (mem_req !== 1'b1) bad("word_req");
    tests++; if (mem_wr !== 1'b0) bad("word_wr0");
    wr(32'h100, 8'hD4); wr(32'h101, 8'hC3); wr(32'h102, 8'hB2); wr(32'h103, 8'hA1);
    fin;

    rec(5, 32'h30000, 32'h55, 0);
    io_buffer_full = 1;
    commit(5, `SType);
    idle_wr; idle_wr; idle_wr;
    io_buffer_full = 0;
    wr(32'h30000, 8'h55);
    fin;

    rec(7, 32'h200, 32'h0000BEEF, 1);
    commit(7, `SType);
    wr(32'h200, 8'hEF);
    mem_gnt = 0;
    idle_wr;
    mem_gnt = 1;
    wr(32'h201, 8'hBE);
    fin;

    rec(1, 32'h10, 32'h1, 2);
    rec(2, 32'h20, 32'h2, 2);
    roll_back = 1; step; roll_back = 0;
    commit(1, `SType);
    tests++; if (store_err !== 1'b1) bad("inv_err");
    tests++; if (mem_wr !== 1'b0) bad("inv_wr");
    tests++; if (mem_req !== 1'b0) bad("inv_req");
    fin;
    tests++; if (store_err !== 1'b1) bad("err_sticky");

    rec(4, 32'h400, 32'h11223344, 2);
    commit(4, `SType);
    wr(32'h400, 8'h44);
    rdy_in = 0;
    wr(32'h400, 8'h44);
    wr(32'h400, 8'h44);
    tests++; if (finish_store !== 1'b0) bad("pause_fin");
    rdy_in = 1;
    wr(32'h401, 8'h33); wr(32'h402, 8'h22); wr(32'h403, 8'h11);
    fin;

    rec(8, 32'hFFFFFFFF, 32'h0000A55A, 1);
    commit(8, 3'd0);
    tests++; if (mem_req !== 1'b0) bad("nonstore_req");
    step;
    tests++; if (finish_store !== 1'b0) bad("nonstore_fin");
    commit(8, `SType);
    tests++; if (mem_req !== 1'b1) bad("keep_valid_req");
    wr(32'hFFFFFFFF, 8'h5A);
    wr(32'h00000000, 8'hA5);
    fin;

    rec(6, 32'h500, 32'hCAFEF00D, 2);
    commit(6, `SType);
    wr(32'h500, 8'h0D);
    #3 rst_in = 1;
    #1;
    tests++; if (mem_wr !== 1'b0) bad("arst_wr");
    tests++; if (mem_req !== 1'b0) bad("arst_req");
    tests++; if (mem_a !== 32'h0) bad("arst_a");
    tests++; if (mem_dout !== 8'h0) bad("arst_d");
    tests++; if (store_err !== 1'b0) bad("arst_err");
    tests++; if (finish_store !== 1'b0) bad("arst_fin");
    #1 rst_in = 0;
    for (int i = 0; i < 4; i++) begin
      step;
      tests++; if (finish_store !== 1'b0) bad("post_rst_fin");
      tests++; if (mem_wr !== 1'b0) bad("post_rst_wr");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
